wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RISC-V core, sitting directly upstream of the register bank and driving its write port (`Reg_write`, `Wr_reg`, `Wr_data`). It merges two result streams:

- single-cycle ALU results, over a valid/ready handshake;
- load responses from the data-memory path, which cannot be stalled.

It sign- or zero-extends load data per funct3, suppresses writes to x0, and keeps a load scoreboard so decode can stall on registers with an outstanding load.

## Interface
Parameters:
- N_ADDR, 5, register address width
- N_REG, 32, number of architectural registers (scoreboard size)
- N_BIT, 32, data width

Ports:
- Clk  in  1  clock, all state on posedge
- Rst  in  1  reset, synchronous, active-high
- Alu_valid  in  1  ALU result present
- Alu_ready  out  1  stage accepts ALU result this cycle
- Alu_rd  in  N_ADDR  ALU destination register
- Alu_data  in  N_BIT  ALU result
- Ld_issue  in  1  load issued to memory this cycle (scoreboard set)
- Ld_issue_rd  in  N_ADDR  destination of issued load
- Ld_valid  in  1  load response present (must be taken)
- Ld_rd  in  N_ADDR  load response destination
- Ld_data  in  N_BIT  raw aligned memory word
- Ld_addr_lo  in  2  byte offset of load address
- Ld_funct3  in  3  load type
- Chk_reg_1, Chk_reg_2  in  N_ADDR  source registers queried by decode
- Chk_busy  out  1  either queried source has an outstanding load
- Sb_err  out  1  sticky: load response to a non-busy register
- Reg_write  out  1  write strobe to register bank
- Wr_reg  out  N_ADDR  write address
- Wr_data  out  N_BIT  write data

## Operation
- `Alu_ready = !Rst && !Ld_valid`. Loads always have priority; an ALU result waits, with its inputs held stable by the producer, until accepted.
- ALU accept: `Alu_valid && Alu_ready`. The accepted result is registered to `Wr_reg`/`Wr_data`.
- Load accept: every cycle with `Ld_valid` and not `Rst`. The data is extended, then registered.
- Load extension:
  - Byte lane = `Ld_addr_lo*8`; half lane = `Ld_addr_lo[1]*16`.
  - funct3 000 LB: sign-extend byte.
  - funct3 001 LH: sign-extend half.
  - funct3 010 LW: full word, `Ld_addr_lo` ignored.
  - funct3 100 LBU: zero-extend byte.
  - funct3 101 LHU: zero-extend half.
  - funct3 011, 110, 111: treated as LW.
- x0 filter: an accepted result with rd=0 is consumed, but `Reg_write` is 0 that cycle and `Wr_reg`/`Wr_data` hold their previous values.
- Scoreboard (`busy[N_REG]`):
  - Set: `Ld_issue` with `Ld_issue_rd!=0` sets `busy[Ld_issue_rd]`.
  - Clear: an accepted load response clears `busy[Ld_rd]`.
  - Same rd set and cleared in one cycle: set wins.
  - `busy[0]` is always 0.
- `Chk_busy = busy[Chk_reg_1] | busy[Chk_reg_2]`, combinational from registered state. It does not see a same-cycle `Ld_issue`.
- `Sb_err` is set when an accepted load has `Ld_rd!=0` and `busy[Ld_rd]==0`. It is cleared only by `Rst`.

## Timing
- Latency: accept at edge N, so `Reg_write`/`Wr_reg`/`Wr_data` are valid in cycle N+1, for exactly one cycle per accepted result.
- Throughput: one write per cycle. Back-to-back loads starve the ALU input indefinitely, by design.
- Scoreboard updates are visible on `Chk_busy` the cycle after the issuing or clearing edge.
- Reset values:
  - `Reg_write=0`, `Wr_reg=0`, `Wr_data=0`, `Sb_err=0`, all `busy=0`.
  - `Alu_ready=0` while `Rst` is high.
  - `Chk_busy=0` the cycle after reset.
- Rst mid-operation: inputs presented during a `Rst` cycle are discarded, and no write is produced for them.
- `Ld_valid` and `Alu_valid` in the same cycle: the load is written at N+1; the ALU result is accepted on the first cycle without `Ld_valid`.

## Configuration
- `WB_SCOREBOARD_EN` defined: scoreboard, `Chk_busy` and `Sb_err` are implemented as above.
- Not defined:
  - No scoreboard storage.
  - `Chk_busy` and `Sb_err` are tied to 0.
  - `Ld_issue`/`Ld_issue_rd` are ignored.
  - Writeback behaviour is unchanged.

## Test plan
- ALU only: `Alu_valid=1`, rd=5, data=0x1234_5678 -> `Alu_ready=1`; next cycle `Reg_write=1`, `Wr_reg=5`, `Wr_data=0x12345678`.
- Collision: ALU rd=3 data=0xAA and load rd=4 LW 0xDEADBEEF in the same cycle -> `Alu_ready=0`; cycle+1 writes r4=0xDEADBEEF; cycle+2 writes r3=0xAA.
- Extension, `Ld_data=0x80FF7F01`:
  - LB, lo=3 -> 0xFFFFFF80.
  - LBU, lo=1 -> 0x0000007F.
  - LH, lo=2 -> 0xFFFF80FF.
  - LHU, lo=0 -> 0x00007F01.
- x0: ALU rd=0 data=0x55 -> consumed (`Alu_ready=1`), `Reg_write` stays 0, `Wr_data` unchanged.
- Scoreboard (`WB_SCOREBOARD_EN`):
  - `Ld_issue` rd=7 -> `Chk_busy=1` for `Chk_reg_1=7` from the next cycle.
  - Load response rd=7 -> `Chk_busy=0` the cycle after.
  - Response rd=9 with no prior issue -> `Sb_err=1`, held until `Rst`.
  - Same-cycle issue and response for rd=7 -> stays busy.
- Reset mid-stream: `Rst` asserted with `Ld_valid` and `Alu_valid` high -> no `Reg_write` in the following cycle, all outputs 0, scoreboard cleared.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the RISC-V core.
//
// This stage merges single-cycle ALU results with load responses. It drives
// the register bank write port one cycle after it accepts a result.
//
// Loads cannot be stalled, so they always win over the ALU. An ALU result
// that loses waits, and its producer keeps the inputs stable. Load data is
// lane-selected and sign- or zero-extended according to funct3. Results that
// target x0 are consumed without producing a write.
//
// Optional feature, selected by the macro WB_SCOREBOARD_EN:
//   defined   - a per-register load scoreboard drives Chk_busy and Sb_err
//   undefined - no scoreboard; Chk_busy and Sb_err are tied to 0, and
//               Ld_issue/Ld_issue_rd are ignored
//
// Parameters:
//   N_ADDR  register address width
//   N_REG   number of architectural registers (scoreboard size)
//   N_BIT   data width (byte/half lanes are taken from the low 32 bits)
//
// Ports:
//   Clk, Rst              clock, synchronous active-high reset
//   Alu_valid/ready       ALU result handshake; Alu_rd, Alu_data carry the payload
//   Ld_issue, Ld_issue_rd load issued to memory (sets the scoreboard)
//   Ld_valid, Ld_rd       load response, always taken when not in reset
//   Ld_data               raw aligned memory word
//   Ld_addr_lo, Ld_funct3 byte offset and load type
//   Chk_reg_1/2, Chk_busy decode query: does either source have a pending load
//   Sb_err                sticky: a load response arrived for a non-busy register
//   Reg_write, Wr_reg, Wr_data  register bank write port
module wb_stage #(
  parameter int N_ADDR = 5,
  parameter int N_REG  = 32,
  parameter int N_BIT  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Alu_valid,
  output logic              Alu_ready,
  input  logic [N_ADDR-1:0] Alu_rd,
  input  logic [N_BIT-1:0]  Alu_data,
  input  logic              Ld_issue,
  input  logic [N_ADDR-1:0] Ld_issue_rd,
  input  logic              Ld_valid,
  input  logic [N_ADDR-1:0] Ld_rd,
  input  logic [N_BIT-1:0]  Ld_data,
  input  logic [1:0]        Ld_addr_lo,
  input  logic [2:0]        Ld_funct3,
  input  logic [N_ADDR-1:0] Chk_reg_1,
  input  logic [N_ADDR-1:0] Chk_reg_2,
  output logic              Chk_busy,
  output logic              Sb_err,
  output logic              Reg_write,
  output logic [N_ADDR-1:0] Wr_reg,
  output logic [N_BIT-1:0]  Wr_data
);

  logic             alu_acc;
  logic             ld_acc;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [N_BIT-1:0] ld_ext;

  assign Alu_ready = !Rst && !Ld_valid;
  assign alu_acc   = Alu_valid && Alu_ready;
  assign ld_acc    = Ld_valid && !Rst;

  always_comb begin
    ld_byte = Ld_data[7:0];
    case (Ld_addr_lo)
      2'd0: ld_byte = Ld_data[7:0];
      2'd1: ld_byte = Ld_data[15:8];
      2'd2: ld_byte = Ld_data[23:16];
      2'd3: ld_byte = Ld_data[31:24];
      default: ld_byte = Ld_data[7:0];
    endcase
    ld_half = Ld_addr_lo[1] ? Ld_data[31:16] : Ld_data[15:0];
  end

  // funct3 011, 110 and 111 have no load meaning here and fall back to LW.
  always_comb begin
    ld_ext = Ld_data;
    case (Ld_funct3)
      3'b000:  ld_ext = {{(N_BIT-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(N_BIT-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(N_BIT-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(N_BIT-16){1'b0}}, ld_half};
      default: ld_ext = Ld_data;
    endcase
  end

  // A result for x0 is consumed, but the write port holds its last address
  // and data, so the bank never sees a stale-address write.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Reg_write <= 1'b0;
      Wr_reg    <= '0;
      Wr_data   <= '0;
    end else begin
      Reg_write <= 1'b0;
      if (ld_acc) begin
        if (Ld_rd != '0) begin
          Reg_write <= 1'b1;
          Wr_reg    <= Ld_rd;
          Wr_data   <= ld_ext;
        end
      end else if (alu_acc) begin
        if (Alu_rd != '0) begin
          Reg_write <= 1'b1;
          Wr_reg    <= Alu_rd;
          Wr_data   <= Alu_data;
        end
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [N_REG-1:0] busy;
  logic [N_REG-1:0] busy_nxt;

  // The clear is applied before the set, so an issue and a response to the
  // same register in one cycle leave that register busy.
  always_comb begin
    busy_nxt = busy;
    if (ld_acc) busy_nxt[Ld_rd] = 1'b0;
    if (Ld_issue && (Ld_issue_rd != '0)) busy_nxt[Ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy   <= '0;
      Sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (ld_acc && (Ld_rd != '0) && !busy[Ld_rd]) Sb_err <= 1'b1;
    end
  end

  assign Chk_busy = busy[Chk_reg_1] | busy[Chk_reg_2];
`else
  logic unused_sb;
  assign unused_sb = ^{Ld_issue, Ld_issue_rd, Chk_reg_1, Chk_reg_2};
  assign Chk_busy  = 1'b0;
  assign Sb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage.
// The bench runs directed cases first and then a randomized stream. Each cycle
// is compared against a behavioural model that keeps the scoreboard as an
// array of bits and computes load extension with shifts and masks.
// The bench follows the WB_SCOREBOARD_EN setting of the build.
module tb_wb_stage;

  logic        clk_sys;
  logic        rst;
  logic        alu_v;
  logic        alu_rdy;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_iss;
  logic [4:0]  ld_iss_rd;
  logic        ld_v;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [1:0]  ld_lo;
  logic [2:0]  ld_f3;
  logic [4:0]  chk1, chk2;
  logic        chk_busy, sb_err, reg_wr;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  wb_stage dut (
    .Clk(clk_sys), .Rst(rst),
    .Alu_valid(alu_v), .Alu_ready(alu_rdy), .Alu_rd(alu_rd), .Alu_data(alu_data),
    .Ld_issue(ld_iss), .Ld_issue_rd(ld_iss_rd),
    .Ld_valid(ld_v), .Ld_rd(ld_rd), .Ld_data(ld_data),
    .Ld_addr_lo(ld_lo), .Ld_funct3(ld_f3),
    .Chk_reg_1(chk1), .Chk_reg_2(chk2), .Chk_busy(chk_busy), .Sb_err(sb_err),
    .Reg_write(reg_wr), .Wr_reg(wr_reg), .Wr_data(wr_data)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_busy [32];
  bit          m_sberr;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          alu_taken;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (d >> (lo * 8)) & 32'hFF;
    h = (d >> (lo[1] * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check registered outputs just after the edge.
  task automatic cycle();
    bit exp_rdy;
    @(negedge clk_sys);
    exp_rdy = !rst && !ld_v;
    check("alu_ready", alu_rdy, exp_rdy);
    check("chk_busy", chk_busy, (m_busy[chk1] || m_busy[chk2]) ? 1 : 0);
    alu_taken = alu_v && exp_rdy;
    if (rst) begin
      m_we = 0; m_reg = 0; m_data = 0; m_sberr = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      m_we = 0;
      if (ld_v) begin
        if (ld_rd != 0) begin
          m_we = 1; m_reg = ld_rd; m_data = load_ext(ld_data, ld_lo, ld_f3);
          if (SB && !m_busy[ld_rd]) m_sberr = 1;
        end
        m_busy[ld_rd] = 0;
      end else if (alu_taken && alu_rd != 0) begin
        m_we = 1; m_reg = alu_rd; m_data = alu_data;
      end
      if (SB && ld_iss && ld_iss_rd != 0) m_busy[ld_iss_rd] = 1;
    end
    @(posedge clk_sys);
    #1;
    check("reg_write", reg_wr, m_we);
    check("wr_reg", wr_reg, m_reg);
    check("wr_data", wr_data, m_data);
    check("sb_err", sb_err, m_sberr);
  endtask

  task automatic idle_inputs();
    alu_v = 0; ld_iss = 0; ld_v = 0;
  endtask

  typedef struct { logic [2:0] f3; logic [1:0] lo; logic [31:0] exp; } ext_t;
  ext_t ext_tab [4];

  initial begin
    rst = 1; alu_v = 0; alu_rd = 0; alu_data = 0; ld_iss = 0; ld_iss_rd = 0;
    ld_v = 0; ld_rd = 0; ld_data = 0; ld_lo = 0; ld_f3 = 0; chk1 = 0; chk2 = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_sberr = 0; m_we = 0; m_reg = 0; m_data = 0;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    cycle();
    check("rst_we", reg_wr, 0);
    check("rst_data", wr_data, 0);
    rst = 0;
    cycle();
    check("rst_chk_busy", chk_busy, 0);

    // scoreboard: issue r7, respond r7, same-cycle issue and response
    chk1 = 7; chk2 = 0;
    ld_iss = 1; ld_iss_rd = 7;
    cycle();
    ld_iss = 0;
    check("busy7_set", chk_busy, SB ? 1 : 0);
    ld_v = 1; ld_rd = 7; ld_data = 32'h1; ld_f3 = 3'd2; ld_lo = 0;
    cycle();
    ld_v = 0;
    check("busy7_clr", chk_busy, 0);
    check("sb_err_ok", sb_err, 0);
    ld_iss = 1; ld_iss_rd = 7;
    cycle();
    ld_iss = 1; ld_iss_rd = 7; ld_v = 1; ld_rd = 7;
    cycle();
    idle_inputs();
    check("busy7_same", chk_busy, SB ? 1 : 0);
    ld_v = 1; ld_rd = 9; ld_data = 32'h9;
    cycle();
    ld_v = 0;
    check("sb_err_r9", sb_err, SB ? 1 : 0);
    cycle();
    check("sb_err_hold", sb_err, SB ? 1 : 0);

    // reset mid-stream with pending load state
    ld_iss = 1; ld_iss_rd = 12;
    cycle();
    rst = 1; ld_iss = 0; ld_v = 1; ld_rd = 3; alu_v = 1; alu_rd = 4; alu_data = 32'h77;
    cycle();
    check("mid_rst_we", reg_wr, 0);
    check("mid_rst_reg", wr_reg, 0);
    check("mid_rst_err", sb_err, 0);
    rst = 0; idle_inputs(); chk1 = 12;
    cycle();
    check("mid_rst_busy", chk_busy, 0);

    // ALU only
    alu_v = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    cycle();
    alu_v = 0;
    check("alu_we", reg_wr, 1);
    check("alu_reg", wr_reg, 5);
    check("alu_data", wr_data, 32'h1234_5678);

    // collision: load first, ALU next cycle
    alu_v = 1; alu_rd = 3; alu_data = 32'hAA;
    ld_v = 1; ld_rd = 4; ld_data = 32'hDEAD_BEEF; ld_f3 = 3'd2; ld_lo = 2'd1;
    cycle();
    ld_v = 0;
    check("col_ld_reg", wr_reg, 4);
    check("col_ld_data", wr_data, 32'hDEAD_BEEF);
    cycle();
    alu_v = 0;
    check("col_alu_reg", wr_reg, 3);
    check("col_alu_data", wr_data, 32'hAA);

    // load extension
    ext_tab[0] = '{3'd0, 2'd3, 32'hFFFF_FF80};
    ext_tab[1] = '{3'd4, 2'd1, 32'h0000_007F};
    ext_tab[2] = '{3'd1, 2'd2, 32'hFFFF_80FF};
    ext_tab[3] = '{3'd5, 2'd0, 32'h0000_7F01};
    foreach (ext_tab[i]) begin
      ld_v = 1; ld_rd = 10; ld_data = 32'h80FF_7F01;
      ld_f3 = ext_tab[i].f3; ld_lo = ext_tab[i].lo;
      cycle();
      check($sformatf("ext%0d", i), wr_data, ext_tab[i].exp);
    end
    ld_v = 0;

    // x0 write is consumed without a write
    alu_v = 1; alu_rd = 0; alu_data = 32'h55;
    cycle();
    alu_v = 0;
    check("x0_taken", alu_taken, 1);
    check("x0_we", reg_wr, 0);
    check("x0_data", wr_data, 32'h0000_7F01);

    // randomized stream
    for (int n = 0; n < 1500; n++) begin
      if (!alu_v || alu_taken) begin
        alu_v = ($urandom_range(0, 9) < 6);
        alu_rd = 5'($urandom_range(0, 31));
        alu_data = $urandom;
      end
      rst = ($urandom_range(0, 63) == 0);
      ld_v = ($urandom_range(0, 9) < 4);
      ld_rd = 5'($urandom_range(0, 31));
      ld_data = $urandom;
      ld_lo = 2'($urandom_range(0, 3));
      ld_f3 = 3'($urandom_range(0, 7));
      ld_iss = ($urandom_range(0, 9) < 4);
      ld_iss_rd = 5'($urandom_range(0, 31));
      chk1 = 5'($urandom_range(0, 31));
      chk2 = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
